// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
//   lsu_state_t    : access FSM states
//   F3_*           : funct3 access size/sign encodings
//   RESULT_SRC_MEM : ResultSrcM encoding that selects memory load data
//   lsu_req_t      : store-side bus request fields formed per byte lane
package lsu_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = NUM_LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef struct packed {
    logic                              we;
    logic [NUM_LANES-1:0]              wstrb;
    logic [NUM_LANES-1:0][LANE_W-1:0]  wdata;
  } lsu_req_t;

  // Halfword-sized encodings (H/HU) need addr[0]=0; only a true word
  // access needs addr[1:0]=0. Other encodings are never misaligned.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) ||
           ((f3 == F3_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for the load/store unit.
//   funct3  : access size/sign
//   addr_lo : low two bits of the effective byte address
//   wd      : raw store data (rs2)
//   rdata   : raw bus read word
//   wdata   : lane-replicated store data (one byte per lane)
//   wstrb   : byte enables for the store
//   ldata   : extracted and sign/zero-extended load data
//   misalign: (LSU_MISALIGN_TRAP_EN only) access is not naturally aligned
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]                        funct3,
  input  logic [1:0]                        addr_lo,
  input  logic [VEC_W-1:0]                  wd,
  input  logic [VEC_W-1:0]                  rdata,
  output logic [NUM_LANES-1:0][LANE_W-1:0]  wdata,
  output logic [NUM_LANES-1:0]              wstrb,
  output logic [VEC_W-1:0]                  ldata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                              misalign
`endif
);

  logic [NUM_LANES-1:0][LANE_W-1:0] wd_b;
  logic [NUM_LANES-1:0][LANE_W-1:0] rd_b;

  assign wd_b = wd;
  assign rd_b = rdata;

  // Each lane decides its own enable and which source byte it carries.
  // Byte stores replicate byte 0 everywhere, halfword stores replicate
  // the low half, so the bus slave only has to honour the strobes.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic             s;
    logic [LANE_W-1:0] d;

    always_comb begin
      s = 1'b0;
      d = wd_b[i];
      case (funct3)
        F3_B: begin
          s = (addr_lo == 2'(i));
          d = wd_b[0];
        end
        F3_H: begin
          s = (addr_lo[1] == 1'(i / 2));
          d = wd_b[i % 2];
        end
        F3_W: begin
          s = 1'b1;
          d = wd_b[i];
        end
        default: ;
      endcase
    end

    assign wstrb[i] = s;
    assign wdata[i] = d;
  end

  logic [LANE_W-1:0]   ld_byte;
  logic [2*LANE_W-1:0] ld_half;

  always_comb begin
    ld_byte = rd_b[addr_lo];
    ld_half = addr_lo[1] ? {rd_b[3], rd_b[2]} : {rd_b[1], rd_b[0]};
    case (funct3)
      F3_B:    ldata = {{(VEC_W-LANE_W){ld_byte[LANE_W-1]}}, ld_byte};
      F3_BU:   ldata = {{(VEC_W-LANE_W){1'b0}}, ld_byte};
      F3_H:    ldata = {{(VEC_W-2*LANE_W){ld_half[2*LANE_W-1]}}, ld_half};
      F3_HU:   ldata = {{(VEC_W-2*LANE_W){1'b0}}, ld_half};
      default: ldata = rdata;  // LW and undefined encodings: raw word
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(funct3, addr_lo);
`endif

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Issues one valid/ready bus request per
// memory instruction in M, waits for the read response on loads, and
// holds the pipeline-wide Stall while the access is outstanding.
//   clk, rst        : clock, synchronous active-high reset
//   MemWriteM       : store in M
//   ResultSrcM      : 2'b01 marks a load
//   Funct3M         : access size/sign
//   ALUResultM      : effective byte address
//   WriteDataM      : store data
//   Stall           : freezes upstream pipeline registers
//   ReadDataM       : registered, extended load data
//   MemValid/Ready  : request handshake
//   MemWe/Addr/Wdata/Wstrb : request payload
//   MemRvalid/Rdata : read response
//   MisalignM       : misaligned-access pulse (LSU_MISALIGN_TRAP_EN only)
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword and
// word accesses instead of truncating them.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [2:0]        Funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic              Stall,
  output logic [XLEN-1:0]   ReadDataM,
  output logic              MemValid,
  input  logic              MemReady,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [XLEN-1:0]   MemWdata,
  output logic [XLEN/8-1:0] MemWstrb,
  input  logic              MemRvalid,
  input  logic [XLEN-1:0]   MemRdata
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              MisalignM
`endif
);

  lsu_state_t state, nxt;
  logic       access;
  logic       is_store;
  lsu_req_t   req;
  logic [XLEN-1:0] ldata;

  // A store wins if the decoder ever flags both write and load.
  assign is_store = MemWriteM;
  assign access   = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign;
`endif

  lsu_align u_align (
    .funct3  (Funct3M),
    .addr_lo (ALUResultM[1:0]),
    .wd      (WriteDataM),
    .rdata   (MemRdata),
    .wdata   (req.wdata),
    .wstrb   (req.wstrb),
    .ldata   (ldata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign(misalign)
`endif
  );

  assign req.we = is_store;

  // The pipeline is frozen while Stall is high, so the M-stage inputs
  // (and hence the payload) stay stable across REQ without extra flops.
  assign MemWe    = req.we;
  assign MemAddr  = {ALUResultM[ADDR_W-1:2], 2'b00};
  assign MemWdata = req.wdata;
  assign MemWstrb = req.wstrb;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt      = state;
    MemValid = 1'b0;
    Stall    = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    MisalignM = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (access) begin
          Stall = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          if (misalign) begin
            MisalignM = 1'b1;
            nxt       = DONE;
          end else
`endif
          begin
            MemValid = 1'b1;
            if (MemReady) nxt = is_store ? DONE : RESP;
            else          nxt = REQ;
          end
        end
      end
      REQ: begin
        MemValid = 1'b1;
        Stall    = 1'b1;
        if (MemReady) nxt = is_store ? DONE : RESP;
      end
      RESP: begin
        Stall = 1'b1;
        if (MemRvalid) nxt = DONE;
      end
      // One unstalled cycle lets the instruction leave M; no new request
      // is issued here even though the M inputs still show an access.
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Only a response that arrives in RESP is captured; stray or
  // post-reset responses fall through.
  always_ff @(posedge clk) begin
    if (rst)                              ReadDataM <= '0;
    else if ((state == RESP) && MemRvalid) ReadDataM <= ldata;
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases followed by random
// loads/stores against a transaction-level reference model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic        Stall;
  logic [31:0] ReadDataM;
  logic        MemValid;
  logic        MemReady;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWdata;
  logic [3:0]  MemWstrb;
  logic        MemRvalid;
  logic [31:0] MemRdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        MisalignM;
`endif

  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] model_rd;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk        (clk),
    .rst        (rst),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .Stall      (Stall),
    .ReadDataM  (ReadDataM),
    .MemValid   (MemValid),
    .MemReady   (MemReady),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWdata   (MemWdata),
    .MemWstrb   (MemWstrb),
    .MemRvalid  (MemRvalid),
    .MemRdata   (MemRdata)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .MisalignM  (MisalignM)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model ----
  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned off = a % 4;
    case (f3)
      3'd0:    return 4'(1 << off);
      3'd1:    return (off >= 2) ? 4'b1100 : 4'b0011;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] b = {24'd0, wd[7:0]};
    logic [31:0] h = {16'd0, wd[15:0]};
    case (f3)
      3'd0:    return b * 32'h01010101;
      3'd1:    return h * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
    int unsigned off = a % 4;
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128)   ? b - 32'd256   : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [1:0] non_mem_src();
    case ($urandom_range(0, 2))
      0:       return 2'b00;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  task automatic drive_idle();
    MemWriteM  = 1'b0;
    ResultSrcM = non_mem_src();
    Funct3M    = 3'($urandom_range(0, 7));
    ALUResultM = $urandom;
    WriteDataM = $urandom;
    MemReady   = 1'($urandom_range(0, 1));
    MemRvalid  = 1'($urandom_range(0, 1));
    MemRdata   = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      @(negedge clk);
      check("idle_stall", 32'(Stall), 32'd0);
      check("idle_valid", 32'(MemValid), 32'd0);
      check("idle_rdata", ReadDataM, model_rd);
      next_cycle();
    end
  endtask

  // One memory instruction held in M until it completes. rdy = cycles the
  // slave keeps MemReady low; rv = cycles from acceptance to MemRvalid.
  task automatic do_access(input logic we, input logic ld, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int rdy, input int rv, input logic [31:0] rdat);
    logic trap;
    int   exp_stall, exp_valid;
    int   stall_cnt, valid_cnt, mis_cnt;
    logic done;
    int   k;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = ((f3 % 4 == 1) && (a % 2 == 1)) || ((f3 == 3'd2) && (a % 4 != 0));
`endif
    exp_stall = trap ? 1 : (we ? rdy + 1 : rdy + rv + 1);
    exp_valid = trap ? 0 : rdy + 1;
    if (!we && !trap) model_rd = model_load(f3, a, rdat);
    stall_cnt = 0; valid_cnt = 0; mis_cnt = 0; done = 1'b0; k = 0;

    MemWriteM  = we;
    ResultSrcM = ld ? 2'b01 : non_mem_src();
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    while (!done && k < 64) begin
      MemReady = (k >= rdy);
      if (!we && k == rdy + rv) begin
        MemRvalid = 1'b1;
        MemRdata  = rdat;
      end else if (k < rdy) begin
        MemRvalid = 1'($urandom_range(0, 1));  // stray, must be ignored
        MemRdata  = $urandom;
      end else begin
        MemRvalid = 1'b0;
        MemRdata  = $urandom;
      end
      @(negedge clk);
      if (Stall) stall_cnt++;
      else       done = 1'b1;
      if (MemValid) begin
        valid_cnt++;
        check("req_addr", MemAddr, a - (a % 4));
        check("req_we",   32'(MemWe), 32'(we));
        if (we) begin
          check("req_strb", 32'(MemWstrb), 32'(model_strb(f3, a)));
          if (f3 <= 3'd2) check("req_wdata", MemWdata, model_wdata(f3, wd));
        end
      end
`ifdef LSU_MISALIGN_TRAP_EN
      if (MisalignM) mis_cnt++;
`endif
      if (done) check("done_rdata", ReadDataM, model_rd);
      next_cycle();
      k++;
    end
    check("completed",   32'(done), 32'd1);
    check("stall_cycles", stall_cnt, exp_stall);
    check("valid_cycles", valid_cnt, exp_valid);
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign_pulses", mis_cnt, trap ? 1 : 0);
`else
    check("misalign_pulses", mis_cnt, 0);
`endif
    drive_idle();
  endtask

  initial begin
    logic        we, ld;
    logic [2:0]  f3;
    logic [31:0] a;

    rst = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_valid", 32'(MemValid), 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    next_cycle();
    rst = 1'b0;
    model_rd = 32'd0;
    idle_cycles(2);

    // directed
    do_access(1'b1, 1'b0, 3'b010, 32'h00001004, 32'hDEADBEEF, 0, 1, 32'd0);
    idle_cycles(1);
    do_access(1'b1, 1'b0, 3'b000, 32'h00001003, 32'h000000A5, 0, 1, 32'd0);
    do_access(1'b0, 1'b1, 3'b000, 32'h00002002, 32'd0, 0, 1, 32'h12F03456);
    check("lb_value", ReadDataM, 32'hFFFFFFF0);
    do_access(1'b0, 1'b1, 3'b100, 32'h00002002, 32'd0, 0, 1, 32'h12F03456);
    check("lbu_value", ReadDataM, 32'h000000F0);
    do_access(1'b0, 1'b1, 3'b010, 32'h00004008, 32'd0, 3, 2, 32'h89ABCDEF);
    check("lw_value", ReadDataM, 32'h89ABCDEF);
    do_access(1'b1, 1'b1, 3'b001, 32'h00005002, 32'h1234BEEF, 1, 1, 32'd0);
    do_access(1'b1, 1'b0, 3'b011, 32'h00005000, 32'h11111111, 0, 1, 32'd0);
    do_access(1'b0, 1'b1, 3'b010, 32'h00003001, 32'd0, 0, 1, 32'h55AA55AA);
    do_access(1'b0, 1'b1, 3'b111, 32'h00003002, 32'd0, 1, 3, 32'hC0FFEE01);
    idle_cycles(1);

    // random
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      ld = we ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      a  = $urandom;
      do_access(we, ld, f3, a, $urandom, $urandom_range(0, 3),
                $urandom_range(1, 3), $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    // reset while waiting for a load response; the late response is dropped
    do_access(1'b0, 1'b1, 3'b010, 32'h00006000, 32'd0, 0, 1, 32'hA5A50001);
    MemWriteM  = 1'b0;
    ResultSrcM = 2'b01;
    Funct3M    = 3'b010;
    ALUResultM = 32'h00006004;
    MemReady   = 1'b1;
    MemRvalid  = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(MemValid), 32'd1);
    next_cycle();                 // now waiting in RESP
    rst        = 1'b1;
    ResultSrcM = 2'b00;
    MemReady   = 1'b0;
    next_cycle();
    rst        = 1'b0;
    MemRvalid  = 1'b1;
    MemRdata   = 32'hCAFEF00D;
    model_rd   = 32'd0;
    @(negedge clk);
    check("post_rst_stall", 32'(Stall), 32'd0);
    check("post_rst_valid", 32'(MemValid), 32'd0);
    check("post_rst_rdata", ReadDataM, 32'd0);
    next_cycle();
    MemRvalid = 1'b0;
    @(negedge clk);
    check("late_resp_dropped", ReadDataM, 32'd0);
    next_cycle();
    idle_cycles(2);
    do_access(1'b0, 1'b1, 3'b101, 32'h00007002, 32'd0, 2, 1, 32'h8001F00F);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. Consumes the M-stage signals produced by the execute-to-memory pipeline register.
- Issues one request per memory instruction onto a valid/ready data-memory bus and waits for the response.
- Returns aligned, extended load data.
- Drives the pipeline-wide Stall that freezes the upstream pipeline registers while an access is outstanding.

Parameters:
- XLEN, 32, data width of register file and bus data.
- ADDR_W, 32, bus address width; low ADDR_W bits of ALUResultM.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- MemWriteM  in  1  store in M stage.
- ResultSrcM  in  2  2'b01 = load (result from memory).
- Funct3M  in  3  access size/sign.
- ALUResultM  in  32  effective byte address.
- WriteDataM  in  32  store data (rs2).
- Stall  out  1  freezes upstream pipeline registers.
- ReadDataM  out  32  extended load data.
- MemValid  out  1  bus request valid.
- MemReady  in  1  bus accepts request.
- MemWe  out  1  request is a write.
- MemAddr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- MemWdata  out  32  lane-replicated store data.
- MemWstrb  out  4  byte enables.
- MemRvalid  in  1  read response valid.
- MemRdata  in  32  read response word.

Behaviour:
- access = MemWriteM | (ResultSrcM==2'b01). If both are set, treat as a store.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - access=1: MemValid=1 combinationally and Stall=1.
  - If MemReady is also 1: go to DONE for a store, RESP for a load.
  - If MemReady=0: go to REQ.
  - access=0: Stall=0, MemValid=0, remain IDLE.
- REQ: MemValid=1, Stall=1. Address, data, strobe and we are held stable (the pipeline is frozen). On MemReady, go to DONE for a store, RESP for a load.
- RESP: MemValid=0, Stall=1. On MemRvalid, register the extended MemRdata into ReadDataM and go to DONE.
- DONE: Stall=0 for exactly one cycle so the instruction advances. ReadDataM is valid this cycle. Go to IDLE; no new request is issued in DONE.
- ReadDataM holds its value until the next load completes.
- Latency, zero-wait bus:
  - Store: Stall high 1 cycle.
  - Load with MemRvalid the cycle after acceptance: Stall high 2 cycles; data visible in the 3rd cycle.
- Store lanes:
  - SB (000): wstrb=4'b0001<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH (001): wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{wd[15:0]}}.
  - SW (010): wstrb=4'b1111, wdata=wd.
  - Other funct3 values on a store: wstrb=0, but the handshake still completes.
- Load extraction:
  - LB=000 and LBU=100: byte addr[1:0].
  - LH=001 and LHU=101: half addr[1].
  - LW=010: full word.
  - Signed variants sign-extend, unsigned variants zero-extend.
  - Undefined funct3 values return the raw word.
- MemRvalid outside RESP is ignored.
- MemReady is ignored when MemValid=0.
- Reset, at any point including mid-access:
  - State goes to IDLE.
  - ReadDataM=0, Stall and MemValid follow IDLE rules.
  - A late response after reset is discarded.
- Misaligned addresses (without the optional feature) are truncated per lane rules above; no exception.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: adds output MisalignM (1).
  - In IDLE, a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, issues no request.
  - MisalignM is pulsed for one cycle, and the FSM goes directly to DONE (Stall high that one IDLE cycle). ReadDataM is unchanged.
- Undefined: no port; misaligned accesses are truncated as above.

Decomposition:
- Package lsu_pkg:
  - state enum lsu_state_t {IDLE, REQ, RESP, DONE}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - RESULT_SRC_MEM=2'b01.
- Sub-module lsu_align (combinational):
  - Store wdata/wstrb formation.
  - Load byte/half extraction and extension.
  - Misalign detect.

Test Plan:
- SW addr 0x1004, data 0xDEADBEEF, MemReady=1 -> MemValid 1 cycle, MemAddr 0x1004, MemWstrb 4'hF, Stall high 1 cycle then low 1 cycle.
- SB addr 0x1003, data 0x000000A5 -> MemWstrb 4'b1000, MemWdata 0xA5A5A5A5.
- LB addr 0x2002, MemRdata 0x12F03456 one cycle after acceptance -> ReadDataM 0xFFFFFFF0; LBU -> 0x000000F0; Stall high 2 cycles.
- LW with MemReady low 3 cycles, MemRvalid 2 cycles later -> MemValid/MemAddr stable throughout, Stall high 6 cycles, ReadDataM = MemRdata.
- Reset asserted in RESP, then MemRvalid arrives -> IDLE, ReadDataM 0, response ignored, Stall 0.
- With LSU_MISALIGN_TRAP_EN: LW addr 0x3001 -> no MemValid, MisalignM 1 cycle, Stall 1 cycle.
